// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: mode encodings, Nk/Nr lookups, xtime,
// FSM states and the forward S-box table.
package aes_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [1:0] MODE_128  = 2'b00;
  localparam logic [1:0] MODE_192  = 2'b01;
  localparam logic [1:0] MODE_256  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DRAIN
  } state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      MODE_128: return 4'd4;
      MODE_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_128: return 4'd10;
      MODE_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  function automatic int key_bits(input logic [1:0] mode);
    return 128 + 64 * int'(mode);
  endfunction

  function automatic logic mode_legal(input logic [1:0] mode, input int max_len);
    return (mode != MODE_RSVD) && (key_bits(mode) <= max_len);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit schedule word.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_LEN-1:0] word_in,
  output logic [WORD_LEN-1:0] word_out
);

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule, one 32-bit word per cycle, round keys
// streamed over valid/ready. Optional round-key store: `define AES_KEYEXP_STORE_EN.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_LEN = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_mode,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         key_err,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
`ifdef AES_KEYEXP_STORE_EN
  ,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_data,
  output logic         rd_valid
`endif
);

  state_t                     state;
  // win[k] holds w[i-1-k]; preloaded with the key in reverse word order so
  // win[nk-1] yields the next key word during the first Nk steps.
  logic [7:0][WORD_LEN-1:0]   win;
  logic [7:0][WORD_LEN-1:0]   win_load;
  logic [95:0]                asm_q;
  logic [5:0]                 idx_q;
  logic [5:0]                 last_idx_q;
  logic [2:0]                 pos_q;
  logic [2:0]                 nk_m1_q;
  logic [3:0]                 nr_q;
  logic [7:0]                 rcon_q;

  logic                       mode_ok;
  logic                       in_key;
  logic                       group_end;
  logic                       produce;
  logic                       load_rk;
  logic                       hs_last;
  logic [WORD_LEN-1:0]        t_prev;
  logic [WORD_LEN-1:0]        sbox_in;
  logic [WORD_LEN-1:0]        sbox_out;
  logic [WORD_LEN-1:0]        t_mod;
  logic [WORD_LEN-1:0]        new_word;

  aes_sbox_word u_sbox (
    .word_in  (sbox_in),
    .word_out (sbox_out)
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_load = '0;
    case (key_mode)
      MODE_128: for (int k = 0; k < 4; k++) win_load[k] = key_in[128 + 32*k +: 32];
      MODE_192: for (int k = 0; k < 6; k++) win_load[k] = key_in[64 + 32*k +: 32];
      MODE_256: for (int k = 0; k < 8; k++) win_load[k] = key_in[32*k +: 32];
      default:  win_load = '0;
    endcase
  end

  always_comb begin
    mode_ok   = mode_legal(key_mode, MAX_KEY_LEN);
    in_key    = (idx_q <= {3'b000, nk_m1_q});
    group_end = (idx_q[1:0] == 2'd3);
    produce   = (state == ST_EXPAND) && !(group_end && rk_valid && !rk_ready);
    load_rk   = produce && group_end;
    hs_last   = rk_valid && rk_ready && rk_last;
    t_prev    = win[0];
    sbox_in   = (pos_q == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;
    if (in_key)
      t_mod = '0;
    else if (pos_q == 3'd0)
      t_mod = sbox_out ^ {rcon_q, 24'h000000};
    else if (nk_m1_q == 3'd7 && pos_q == 3'd4)
      t_mod = sbox_out;
    else
      t_mod = t_prev;
    new_word = win[nk_m1_q] ^ t_mod;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      key_ready  <= 1'b1;
      key_err    <= 1'b0;
      busy       <= 1'b0;
      rk_data    <= '0;
      rk_round   <= '0;
      rk_last    <= 1'b0;
      rk_valid   <= 1'b0;
      win        <= '0;
      asm_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      pos_q      <= '0;
      nk_m1_q    <= '0;
      nr_q       <= '0;
      rcon_q     <= '0;
`ifdef AES_KEYEXP_STORE_EN
      rd_valid   <= 1'b0;
`endif
    end else begin
      key_err <= 1'b0;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            if (mode_ok) begin
              state      <= ST_EXPAND;
              key_ready  <= 1'b0;
              busy       <= 1'b1;
              win        <= win_load;
              idx_q      <= '0;
              pos_q      <= '0;
              nk_m1_q    <= 3'(nk_of(key_mode) - 4'd1);
              nr_q       <= nr_of(key_mode);
              last_idx_q <= {nr_of(key_mode), 2'b11};
              rcon_q     <= 8'h01;
`ifdef AES_KEYEXP_STORE_EN
              rd_valid   <= 1'b0;
`endif
            end else begin
              key_err <= 1'b1;
            end
          end
        end

        ST_EXPAND: begin
          if (produce) begin
            win   <= {win[6:0], new_word};
            idx_q <= idx_q + 6'd1;
            pos_q <= (pos_q == nk_m1_q) ? 3'd0 : pos_q + 3'd1;
            if (!in_key && pos_q == 3'd0) rcon_q <= xtime(rcon_q);
            // A completed group overrides the accept-clear above: no bubble.
            if (group_end) begin
              rk_data  <= {asm_q, new_word};
              rk_valid <= 1'b1;
              rk_round <= idx_q[5:2];
              rk_last  <= (idx_q[5:2] == nr_q);
            end else begin
              asm_q <= {asm_q[63:0], new_word};
            end
            if (idx_q == last_idx_q) state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (hs_last) begin
            state     <= ST_IDLE;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            rk_last   <= 1'b0;
`ifdef AES_KEYEXP_STORE_EN
            rd_valid  <= 1'b1;
`endif
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_KEYEXP_STORE_EN
  logic [127:0] store [15];

  // NOTE: the round-key store is deliberately not reset; rd_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (load_rk) store[idx_q[5:2]] <= {asm_q, new_word};
  end

  always_comb begin
    rd_data = '0;
    if (rd_round <= nr_q) rd_data = store[rd_round];
  end
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_in;
  logic [1:0]   key_mode;
  logic         key_valid;
  logic         key_ready, key_err, rk_last, rk_valid, busy;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_ready;

  logic [255:0] k2_key_in;
  logic [1:0]   k2_key_mode;
  logic         k2_key_valid;
  logic         k2_key_ready, k2_key_err, k2_rk_last, k2_rk_valid, k2_busy;
  logic [127:0] k2_rk_data;
  logic [3:0]   k2_rk_round;

`ifdef AES_KEYEXP_STORE_EN
  logic [3:0]   rd_round;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic [127:0] k2_rd_data;
  logic         k2_rd_valid;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_rk   [15];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expander #(.MAX_KEY_LEN(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_mode  (key_mode),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_err   (key_err),
    .rk_data   (rk_data),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
`ifdef AES_KEYEXP_STORE_EN
    ,
    .rd_round  (rd_round),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
`endif
  );

  aes_key_expander #(.MAX_KEY_LEN(128)) dut128 (
    .clk       (clk),
    .reset     (reset),
    .key_in    (k2_key_in),
    .key_mode  (k2_key_mode),
    .key_valid (k2_key_valid),
    .key_ready (k2_key_ready),
    .key_err   (k2_key_err),
    .rk_data   (k2_rk_data),
    .rk_round  (k2_rk_round),
    .rk_last   (k2_rk_last),
    .rk_valid  (k2_rk_valid),
    .rk_ready  (1'b1),
    .busy      (k2_busy)
`ifdef AES_KEYEXP_STORE_EN
    ,
    .rd_round  (4'd0),
    .rd_data   (k2_rd_data),
    .rd_valid  (k2_rd_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic model(input logic [255:0] key, input logic [1:0] mode, output int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          nk;
    nk = 4 + 2 * int'(mode);
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % 8 == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, 128'(key_ready), 128'd1);
    check({tag, "_key_err"},   128'(key_err),   128'd0);
    check({tag, "_rk_valid"},  128'(rk_valid),  128'd0);
    check({tag, "_rk_last"},   128'(rk_last),   128'd0);
    check({tag, "_rk_round"},  128'(rk_round),  128'd0);
    check({tag, "_rk_data"},   rk_data,         128'd0);
    check({tag, "_busy"},      128'(busy),      128'd0);
  endtask

  // Offers one key, then consumes round keys with the given ready probability.
  task automatic run_key(input string tag, input logic [255:0] key, input logic [1:0] mode,
                         input int ready_pct, input bit check_timing,
                         input bit has_last, input logic [127:0] exp_last);
    int           nr;
    int           idx = 0;
    int           cyc = 0;
    bit           done = 0;
    bit           stalled = 0;
    bit           go;
    logic [127:0] held = '0;
    model(key, mode, nr);
    @(negedge clk);
    check({tag, "_ready_before"}, 128'(key_ready), 128'd1);
    key_in    = key;
    key_mode  = mode;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_mode  = 2'(mode + 2'd1);
    check({tag, "_ready_drop"}, 128'(key_ready), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd1);
`ifdef AES_KEYEXP_STORE_EN
    check({tag, "_rd_valid_clr"}, 128'(rd_valid), 128'd0);
`endif
    while (!done && cyc < 600) begin
      if (rk_valid) begin
        if (stalled) check({tag, "_stall_stable"}, rk_data, held);
        else if (check_timing) check({tag, "_timing"}, 128'(cyc), 128'(4*idx + 4));
        go       = ($urandom_range(99) < ready_pct);
        rk_ready = go;
        if (go) begin
          check({tag, "_rk_data"}, rk_data, exp_rk[idx]);
          check({tag, "_rk_round"}, 128'(rk_round), 128'(idx));
          check({tag, "_rk_last"}, 128'(rk_last), 128'(idx == nr));
          if (rk_last) begin
            done = 1;
            if (has_last) check({tag, "_known_vector"}, rk_data, exp_last);
          end
          idx++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = rk_data;
        end
      end else begin
        rk_ready = 1'($urandom_range(1));
        stalled  = 0;
      end
      @(negedge clk);
      cyc++;
    end
    rk_ready = 1'b0;
    check({tag, "_round_count"}, 128'(idx), 128'(nr + 1));
    check({tag, "_ready_back"}, 128'(key_ready), 128'd1);
    check({tag, "_idle"}, 128'(busy), 128'd0);
    check({tag, "_valid_low"}, 128'(rk_valid), 128'd0);
`ifdef AES_KEYEXP_STORE_EN
    check({tag, "_rd_valid"}, 128'(rd_valid), 128'd1);
    rd_round = 4'(nr);
    #1;
    check({tag, "_rd_last"}, rd_data, exp_rk[nr]);
    rd_round = 4'd0;
    #1;
    check({tag, "_rd_first"}, rd_data, exp_rk[0]);
    rd_round = 4'(nr + 1);
    #1;
    check({tag, "_rd_beyond"}, rd_data, 128'd0);
`endif
  endtask

  initial begin
    int           found;
    int           m;
    logic [255:0] rkey;

    reset        = 1'b0;
    key_in       = '0;
    key_mode     = 2'b00;
    key_valid    = 1'b0;
    rk_ready     = 1'b0;
    k2_key_in    = '0;
    k2_key_mode  = 2'b00;
    k2_key_valid = 1'b0;
`ifdef AES_KEYEXP_STORE_EN
    rd_round     = 4'd0;
`endif
    build_sbox();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    run_key("k128", K128, 2'b00, 100, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key("k192", K192, 2'b01, 100, 1'b1, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
    run_key("k256", K256, 2'b10, 100, 1'b1, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
    run_key("k128_bp", K128, 2'b00, 30, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int n = 0; n < 4; n++) begin
      m    = int'($urandom_range(2));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_key("rand_bp", rkey, 2'(m), 30, 1'b0, 1'b0, '0);
    end

    // Reserved mode on the full-width instance.
    @(negedge clk);
    key_mode  = 2'b11;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("rsvd_key_err", 128'(key_err), 128'd1);
    check("rsvd_ready", 128'(key_ready), 128'd1);
    check("rsvd_busy", 128'(busy), 128'd0);
    @(negedge clk);
    check("rsvd_err_pulse", 128'(key_err), 128'd0);

    // Modes wider than MAX_KEY_LEN=128.
    for (int n = 0; n < 2; n++) begin
      found = 0;
      k2_key_mode  = (n == 0) ? 2'b10 : 2'b01;
      k2_key_in    = K256;
      k2_key_valid = 1'b1;
      @(negedge clk);
      k2_key_valid = 1'b0;
      check("wide_key_err", 128'(k2_key_err), 128'd1);
      check("wide_ready", 128'(k2_key_ready), 128'd1);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (k2_rk_valid || k2_busy || k2_key_err) found = 1;
      end
      check("wide_stays_idle", 128'(found), 128'd0);
    end

    // Reset in the middle of round 5, then the same key must stream cleanly.
    model(K128, 2'b00, m);
    @(negedge clk);
    key_in    = K128;
    key_mode  = 2'b00;
    key_valid = 1'b1;
    rk_ready  = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (rk_valid && rk_round == 4'd5) found = 1;
      else @(negedge clk);
    end
    check("mid_round5_seen", 128'(found), 128'd1);
    reset    = 1'b0;
    rk_ready = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_key("after_reset", K128, 2'b00, 100, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Iterative, parametrised AES key-schedule engine. Accepts a 128/192/256-bit cipher key, selected at run time, and streams round keys 0..Nr as 128-bit words over a valid/ready interface, in encryption order. It generates one 32-bit schedule word per cycle and correctly covers every round of every key size. It feeds the round datapath, and replaces the single-round, 128-bit-only sub-key generator.

## Interface
- MAX_KEY_LEN, 256, widest key supported: 128, 192 or 256. Wider modes are rejected.
- WORD_LEN, 32, schedule word width. Fixed by AES; not overridable.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- key_in  in  256  cipher key, MSB-aligned. A 128-bit key occupies [255:128] and a 192-bit key occupies [255:64]. Unused LSBs are ignored.
- key_mode  in  2  00=128, 01=192, 10=256, 11=reserved
- key_valid  in  1  key offered
- key_ready  out  1  block can accept a key (IDLE only)
- key_err  out  1  one-cycle pulse: a reserved mode, or a mode wider than MAX_KEY_LEN, was offered
- rk_data  out  128  round key; w[4r] in [127:96]
- rk_round  out  4  round index r of rk_data
- rk_last  out  1  rk_data is round Nr
- rk_valid  out  1  rk_data valid
- rk_ready  in  1  consumer accepts rk_data
- busy  out  1  expansion in progress

## Operation
- Nk = 4/6/8 and Nr = 10/12/14, latched from key_mode at acceptance. Total schedule words = 4(Nr+1): 44, 52 or 60.
- FSM states are IDLE, EXPAND and DRAIN.
  - IDLE → EXPAND on key_valid && key_ready with a legal mode.
  - An illegal mode is consumed, key_err pulses, and the FSM stays in IDLE.
  - EXPAND → DRAIN when word 4Nr+3 has been produced.
  - DRAIN → IDLE when round Nr is accepted (rk_valid && rk_ready && rk_last).
- key_valid is ignored outside IDLE. There is no abort; the only abort is reset.
- Word index i runs from 0. For i < Nk, w[i] is taken from the latched key. For i ≥ Nk, w[i] = w[i−Nk] ^ t, where t = w[i−1], modified as follows:
  - If i mod Nk = 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}.
  - If Nk = 8 and i mod 8 = 4: t = SubWord(t).
- History is held in an 8-word sliding window.
- rcon starts at 8'h01 and advances after each use by xtime: {rc[6:0],0} ^ (rc[7] ? 8'h1B : 0). The resulting sequence is 01,02,04,08,10,20,40,80,1B,36.
- Words are packed into a 128-bit assembler. When the 4th word of a group arrives, the assembler loads the output register and sets rk_valid, rk_round = group index and rk_last = (group = Nr).
- Backpressure: generation stalls only when the next word would complete a group while rk_valid && !rk_ready. Accept and load in the same cycle is allowed, with no bubble.
- Reset state:
  - State = IDLE.
  - Outputs: key_ready=1, key_err=0, rk_valid=0, rk_last=0, rk_round=0, rk_data=0, busy=0.
  - Window and rcon are cleared.
- Reset mid-expansion discards all state. The next key starts cleanly.

## Timing
- Let E0 be the key-acceptance edge. w[j] is produced at edge E0+1+j when no stall occurs.
- Round r is valid after edge E0+4r+4.
  - Round 0 is valid after E0+4.
  - The last round is valid after E0+44 (128-bit key), E0+52 (192-bit key) or E0+60 (256-bit key).
- With rk_ready held high, round keys are spaced exactly 4 cycles apart.
- key_ready deasserts the cycle after acceptance.
- key_ready reasserts the cycle after the rk_last handshake, giving a minimum of 1 idle cycle between keys.
- busy = (state ≠ IDLE).

## Configuration
- AES_KEYEXP_STORE_EN: stores every round key into an internal (Nr+1)×128 register file as it is emitted. This adds the following ports:
  - rd_round  in  4
  - rd_data  out  128: combinational read of the stored round key
  - rd_valid  out  1: set on the rk_last handshake; cleared on the next key acceptance or on reset
- rd_round > Nr returns 0.
- Without the macro, these ports and the storage are absent, and the block is streaming only.

## Structure
- Package aes_pkg holds:
  - the key_mode encodings
  - the Nk/Nr lookup functions
  - the xtime function
  - the FSM state enum
  - the S-box constant table
- Sub-module aes_sbox_word is a combinational 4-byte S-box (SubWord). There is one instance, shared between the RotWord and plain-SubWord paths through an input mux.

## Test plan
- Apply 128-bit key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready held high → round 0 equals the key; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 after E0+44, with rk_last=1.
- Apply 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 round keys; round 12 = e98ba06f448c773c8ecc720401002202.
- Apply 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 round keys; round 14 = fe4890d1e6188d0b046df344706c631e.
- Drive rk_ready randomly at 30% → identical key sequence with no loss or duplication; rk_data stays stable while stalled.
- Offer key_mode=11, then key_mode=10 with MAX_KEY_LEN=128 → each produces a key_err pulse, no rk_valid, and the FSM stays in IDLE.
- Assert reset at round 5, then apply the 128-bit key above again → all outputs take their reset values; the next run matches the first test exactly. With AES_KEYEXP_STORE_EN: after the rk_last handshake, rd_round=10 returns the round-10 key.
